// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem request in flight and queues returned words for decode.
// Optional same-cycle bypass of an acked word to an empty queue head is enabled by defining IFQ_BYPASS_EN.
module instr_fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instrCode,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t        state_q;
    logic [31:0]   fetchPc_q;
    logic [31:0]   imemAddr_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] rdPtr_q;
    logic [PW-1:0] wrPtr_q;
    logic [31:0]   pcMem_q   [DEPTH];
    logic [31:0]   wordMem_q [DEPTH];

    logic [31:0]   target;
    logic          queueValid;
    logic          reqAck;
    logic          bypass;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_d;
    logic          room;

    assign target     = redirect_pc & 32'hFFFF_FFFC;
    assign queueValid = (count_q != '0);
    assign reqAck     = imem_ack && (state_q == REQ);

`ifdef IFQ_BYPASS_EN
    assign bypass = !queueValid && reqAck && !redirect;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word that decode accepts immediately never occupies a slot.
    assign push    = reqAck && !redirect && !(bypass && instr_ready);
    assign pop     = queueValid && instr_ready;
    assign count_d = count_q + CW'(push) - CW'(pop);
    assign room    = (count_d < DEPTH_C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetchPc_q  <= RESET_PC;
            imemAddr_q <= RESET_PC;
            count_q    <= '0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pcMem_q[i]   <= '0;
                wordMem_q[i] <= '0;
            end
        end else begin
            // Redirect flushes the queue outright; any same-cycle pop or push is moot.
            if (redirect) begin
                count_q <= '0;
                rdPtr_q <= '0;
                wrPtr_q <= '0;
            end else begin
                count_q <= count_d;
                if (push) begin
                    pcMem_q[wrPtr_q]   <= imemAddr_q;
                    wordMem_q[wrPtr_q] <= imem_rdata;
                    wrPtr_q            <= wrPtr_q + PW'(1);
                end
                if (pop) begin
                    rdPtr_q <= rdPtr_q + PW'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (redirect) begin
                        imemAddr_q <= target;
                        fetchPc_q  <= target + 32'd4;
                        state_q    <= REQ;
                    end else if (room) begin
                        imemAddr_q <= fetchPc_q;
                        fetchPc_q  <= fetchPc_q + 32'd4;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            imemAddr_q <= target;
                            fetchPc_q  <= target + 32'd4;
                            state_q    <= REQ;
                        end else if (room) begin
                            imemAddr_q <= fetchPc_q;
                            fetchPc_q  <= fetchPc_q + 32'd4;
                            state_q    <= REQ;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (redirect) begin
                        // The outstanding address must stay put; its response gets dropped later.
                        fetchPc_q <= target;
                        state_q   <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            imemAddr_q <= target;
                            fetchPc_q  <= target + 32'd4;
                        end else begin
                            imemAddr_q <= fetchPc_q;
                            fetchPc_q  <= fetchPc_q + 32'd4;
                        end
                        state_q <= REQ;
                    end else if (redirect) begin
                        fetchPc_q <= target;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = (state_q == REQ) || (state_q == DISCARD);
    assign imem_addr   = imemAddr_q;
    assign instr_valid = queueValid || bypass;
    assign instrCode   = bypass ? imem_rdata : wordMem_q[rdPtr_q];
    assign instr_pc    = bypass ? imemAddr_q : pcMem_q[rdPtr_q];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (default build, DEPTH=2) with a behavioural instruction memory.
// Memory returns addr ^ 32'hDEAD_BEEF after a programmable number of wait cycles.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instrCode;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int ackDelay = 0;
    int waitCnt = 0;
    bit memOn = 1'b0;
    logic [31:0] delivered [$];

    localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;
    logic [31:0] waitExpAddr  [6] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h4, 32'h8};
    logic        waitExpValid [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] waitExpPc    [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4};

    instr_fetch_queue #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instrCode  (instrCode),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    // Memory responder: decides ack on the falling edge so it is stable at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (memOn && imem_req) begin
                if (waitCnt == ackDelay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem_addr ^ MAGIC;
                    waitCnt    = 0;
                end else begin
                    imem_ack = 1'b0;
                    waitCnt++;
                end
            end else begin
                imem_ack = 1'b0;
                waitCnt  = 0;
            end
        end
    end

    // Records the PC of every instruction decode accepts.
    initial begin
        forever begin
            @(posedge clk);
            if (reset && instr_valid && instr_ready) delivered.push_back(instr_pc);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic resetDut(input bit ready, input int delay);
        reset       = 1'b0;
        redirect    = 1'b0;
        instr_ready = ready;
        ackDelay    = delay;
        memOn       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        delivered.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        memOn = 1'b0;
        reset = 1'b0;
        step(2);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (instrCode !== 32'h0) begin errors++; $display("[TB] FAIL reset_code: got %h expected 00000000", instrCode); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 00000000", instr_pc); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00000000", imem_addr); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL release_req_early: got %b expected 0", imem_req); end
        @(posedge clk);
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_addr: got %h expected 00000000", imem_addr); end
    endtask

    task automatic test_stream;
        logic [31:0] expAddr;
        logic [31:0] expPc;
        resetDut(1'b1, 0);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            expAddr = 32'(4 * k);
            expPc   = 32'(4 * (k - 1));
            checks++; if (imem_addr !== expAddr) begin errors++; $display("[TB] FAIL stream_addr: got %h expected %h", imem_addr, expAddr); end
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid: got %b expected 1", instr_valid); end
            checks++; if (instr_pc !== expPc) begin errors++; $display("[TB] FAIL stream_pc: got %h expected %h", instr_pc, expPc); end
            checks++; if (instrCode !== (expPc ^ MAGIC)) begin errors++; $display("[TB] FAIL stream_code: got %h expected %h", instrCode, expPc ^ MAGIC); end
        end
    endtask

    task automatic test_backpressure;
        resetDut(1'b0, 0);
        step(1);
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL bp_addr1: got %h expected 00000004", imem_addr); end
        step(1);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_req: got %b expected 0", imem_req); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL bp_head: got %h expected 00000000", instr_pc); end
        step(2);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_req: got %b expected 0", imem_req); end
        instr_ready = 1'b1;
        step(1);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL bp_relaunch: got req=%b addr=%h expected req=1 addr=00000008", imem_req, imem_addr); end
        checks++; if (instr_pc !== 32'h4) begin errors++; $display("[TB] FAIL bp_second: got %h expected 00000004", instr_pc); end
        step(1);
        instr_ready = 1'b0;
        checks++;
        if (delivered.size() != 2) begin
            errors++; $display("[TB] FAIL bp_order_count: got %0d expected 2", delivered.size());
        end else if (delivered[0] !== 32'h0 || delivered[1] !== 32'h4) begin
            errors++; $display("[TB] FAIL bp_order: got %h,%h expected 00000000,00000004", delivered[0], delivered[1]);
        end
        step(1);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_refill_req: got %b expected 0", imem_req); end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0301;
        step(1);
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("[TB] FAIL idle_redirect: got req=%b addr=%h expected req=1 addr=00000300", imem_req, imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_redirect_flush: got %b expected 0", instr_valid); end
    endtask

    task automatic test_wait_states;
        resetDut(1'b1, 2);
        for (int e = 0; e < 6; e++) begin
            step(1);
            checks++; if (imem_addr !== waitExpAddr[e]) begin errors++; $display("[TB] FAIL wait_addr[%0d]: got %h expected %h", e, imem_addr, waitExpAddr[e]); end
            checks++; if (instr_valid !== waitExpValid[e]) begin errors++; $display("[TB] FAIL wait_valid[%0d]: got %b expected %b", e, instr_valid, waitExpValid[e]); end
            if (waitExpValid[e]) begin
                checks++; if (instr_pc !== waitExpPc[e]) begin errors++; $display("[TB] FAIL wait_pc[%0d]: got %h expected %h", e, instr_pc, waitExpPc[e]); end
            end
        end
    endtask

    task automatic test_redirect_discard;
        int bad;
        resetDut(1'b1, 0);
        step(2);
        memOn       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step(1);
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL discard_hold: got req=%b addr=%h expected req=1 addr=00000008", imem_req, imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL discard_flush: got %b expected 0", instr_valid); end
        memOn = 1'b1;
        step(1);
        checks++; if (imem_addr !== 32'h100 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL discard_target: got addr=%h valid=%b expected addr=00000100 valid=0", imem_addr, instr_valid); end
        step(1);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin errors++; $display("[TB] FAIL discard_deliver: got valid=%b pc=%h expected valid=1 pc=00000100", instr_valid, instr_pc); end
        checks++; if (instrCode !== (32'h100 ^ MAGIC)) begin errors++; $display("[TB] FAIL discard_code: got %h expected %h", instrCode, 32'h100 ^ MAGIC); end
        step(3);
        bad = 0;
        foreach (delivered[i]) if (delivered[i] == 32'h8) bad++;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL discard_dropped: got %0d deliveries of 00000008 expected 0", bad); end
    endtask

    task automatic test_redirect_ack_full;
        resetDut(1'b0, 0);
        step(1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step(1);
        redirect    = 1'b0;
        instr_ready = 1'b1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL ackredir_flush: got %b expected 0", instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL ackredir_req: got req=%b addr=%h expected req=1 addr=00000200", imem_req, imem_addr); end
        step(1);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin errors++; $display("[TB] FAIL ackredir_deliver: got valid=%b pc=%h expected valid=1 pc=00000200", instr_valid, instr_pc); end
        step(2);
        checks++;
        if (delivered.size() == 0) begin
            errors++; $display("[TB] FAIL ackredir_first: got no deliveries expected 00000200");
        end else if (delivered[0] !== 32'h200) begin
            errors++; $display("[TB] FAIL ackredir_first: got %h expected 00000200", delivered[0]);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_reset_mid_discard;
        resetDut(1'b1, 0);
        step(2);
        memOn       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        step(1);
        redirect = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ctrl: got req=%b valid=%b expected 0 0", imem_req, instr_valid); end
        checks++; if (instrCode !== 32'h0 || instr_pc !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL midreset_data: got code=%h pc=%h addr=%h expected all 00000000", instrCode, instr_pc, imem_addr); end
        memOn = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL midreset_restart: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
        step(1);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL midreset_deliver: got valid=%b pc=%h expected valid=1 pc=00000000", instr_valid, instr_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_wait_states();
        test_redirect_discard();
        test_redirect_ack_full();
        test_reset_mid_discard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage directly upstream of the control unit and datapath. Owns the fetch PC, issues word requests to instruction memory over a req/ack handshake with one request outstanding, and buffers returned words in a small queue. It presents `instrCode` and its PC to decode with a valid/ready handshake. A taken-branch redirect from the execute side flushes the queue and discards any in-flight response.

## Interface
- `DEPTH`, 2: queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request; held high until `imem_ack`.
- `imem_addr`  out  32  word address of the request; stable while `imem_req`=1.
- `imem_ack`  in  1  one-cycle response strobe; sampled only while `imem_req`=1.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `redirect`  in  1  taken branch; flush and refetch.
- `redirect_pc`  in  32  new fetch address; bits [1:0] forced to 0.
- `instr_valid`  out  1  queue head valid.
- `instrCode`  out  32  head instruction word to decode.
- `instr_pc`  out  32  PC of head instruction.
- `instr_ready`  in  1  decode consumes head when `instr_valid`&&`instr_ready`.

## Operation
- Registers: `fetch_pc` (next address), `imem_addr` (outstanding address), queue of {pc, word}, `count` width $clog2(DEPTH)+1, rd/wr pointers wrapping modulo DEPTH.
- FSM states IDLE, REQ, DISCARD. `imem_req` = (state==REQ || state==DISCARD).
- "Launch": `imem_addr`<=`fetch_pc`; `fetch_pc`<=`fetch_pc`+4 (32-bit wrap); next state REQ.
- `count_next` = count + push − pop.
- IDLE: redirect → load target (`imem_addr`<=tgt, `fetch_pc`<=tgt+4), REQ. Else if `count_next`<DEPTH → launch. Else stay.
- REQ, no ack: redirect → `fetch_pc`<=tgt, DISCARD. Else hold.
- REQ, ack, no redirect: push {`imem_addr`, `imem_rdata`}; launch if `count_next`<DEPTH, else IDLE.
- REQ, ack, redirect: response dropped, queue flushed, load target, REQ.
- DISCARD: response dropped on ack. Redirect updates `fetch_pc`<=tgt. On ack → launch, using the updated `fetch_pc` if redirect arrived that cycle.
- Redirect priority: clears queue (count=0, pointers=0) at the edge; a same-cycle pop is irrelevant. It never alters `imem_addr` while a request is outstanding.
- Simultaneous push and pop on a full queue is legal; count unchanged.
- `instr_valid` = count≠0; `instrCode`/`instr_pc` = head entry.

## Timing
- Reset (async assert, sync release) values: state IDLE, count 0, `fetch_pc`=`imem_addr`=RESET_PC, queue storage 0. Outputs are `imem_req`=0, `instr_valid`=0, `instrCode`=0, `instr_pc`=0.
- First `imem_req` is seen in the cycle after the first rising edge following reset release, with `imem_addr`=RESET_PC.
- Zero-wait memory (ack in the first req cycle) with ready decode gives one instruction per cycle sustained.
- Ack → `instr_valid` latency is 1 cycle without bypass.
- Redirect at edge N: `instr_valid`=0 after N. If no request is outstanding, or ack coincides with the redirect, `imem_req` to the target is high in cycle N+1.
- Reset asserted mid-request drops the request immediately. Memory must tolerate an abandoned request.

## Configuration
- `IFQ_BYPASS_EN` defined: if count==0 and an ack arrives in REQ without redirect, `instr_valid`=1 the same cycle with `instrCode`=`imem_rdata` and `instr_pc`=`imem_addr`. If `instr_ready`=1 that cycle, the word is not pushed. Ack → valid latency is 0.
- Not defined: no combinational path from `imem_ack`/`imem_rdata` to outputs; latency is 1.

## Test plan
- Reset release, zero-wait memory, ready=1 → fetches 0x0,0x4,0x8,… on consecutive cycles. `instr_pc` follows one cycle behind (same cycle with bypass).
- ready=0, DEPTH=2 → exactly two words queued, then `imem_req`=0. Raising ready relaunches at 0x8 and delivers 0x0 then 0x4 in order.
- Memory with 3-cycle ack delay → `imem_addr` stable across wait cycles; one instruction every 3 cycles.
- Redirect to 0x103 while a request to 0x8 is pending → state DISCARD. The 0x8 word never appears; the next request is 0x100; `instr_pc`=0x100 on delivery.
- Redirect coincident with ack and a full queue → queue empty next cycle; `imem_req` to the target next cycle; dropped word never delivered.
- Reset asserted mid-DISCARD → all outputs return to reset values immediately. After release the fetch restarts at RESET_PC.
